// File: rtl/seq_datapath_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : seq_datapath_arbiter
// Description : Round-robin arbiter/sequencer sharing one sequential datapath
//               between NUM_REQ requesters (valid/ready in, valid/ready out).
//               Optional per-requester grant counters: define SEQ_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_datapath_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int LATENCY   = 1,
    parameter int PRE_CLEAR = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           dp_dataIn,
    output logic                        dp_clear,
    input  logic [DATA_W-1:0]           dp_dataOut,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic                        busy
`ifdef SEQ_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W:0]        c_numReq   = (ID_W+1)'(NUM_REQ);
    localparam logic [3:0]           c_waitLoad = 4'(LATENCY - 1);
    localparam logic [NUM_REQ-1:0]   c_one      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ID_W-1:0]     r_lastGrant;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     w_winner;
    logic [ID_W:0]       w_scanIdx;
    logic                w_anyValid;
    logic                w_handshake;
    logic [NUM_REQ-1:0]  w_grantOneHot;
    logic [DATA_W-1:0]   w_operand;
    logic [DATA_W-1:0]   r_dpDataIn;
    logic                r_dpClear;
    logic [DATA_W-1:0]   r_rspData;
    logic [3:0]          r_waitCnt;

    // Scan downward so the last hit is the nearest requester after last_grant.
    always_comb begin
        w_winner   = '0;
        w_anyValid = 1'b0;
        w_scanIdx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_scanIdx = {1'b0, r_lastGrant} + (ID_W+1)'(k);
            if (w_scanIdx >= c_numReq) begin
                w_scanIdx = w_scanIdx - c_numReq;
            end
            if (req_valid[w_scanIdx[ID_W-1:0]]) begin
                w_winner   = w_scanIdx[ID_W-1:0];
                w_anyValid = 1'b1;
            end
        end
    end

    always_comb begin
        w_operand = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_operand = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_grantOneHot = c_one << w_winner;
    assign w_handshake   = (r_state == S_IDLE) && reset && w_anyValid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        req_ready   = '0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (reset && w_anyValid) begin
                    req_ready = w_grantOneHot;
                end
                if (w_handshake) begin
                    w_nextState = (PRE_CLEAR != 0) ? S_CLEAR : S_WAIT;
                end
            end
            S_CLEAR: w_nextState = S_WAIT;
            S_WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lastGrant <= ID_W'(NUM_REQ - 1);
            r_id        <= '0;
            r_dpDataIn  <= '0;
            r_dpClear   <= 1'b1;
            r_rspData   <= '0;
            r_waitCnt   <= '0;
        end else begin
            r_dpClear <= 1'b0;
            if (w_handshake) begin
                r_lastGrant <= w_winner;
                r_id        <= w_winner;
                r_dpDataIn  <= w_operand;
                r_dpClear   <= (PRE_CLEAR != 0);
            end
            // Counter is armed on entry to WAIT; zero marks the capture cycle.
            if ((w_nextState == S_WAIT) && (r_state != S_WAIT)) begin
                r_waitCnt <= c_waitLoad;
            end else if ((r_state == S_WAIT) && (r_waitCnt != 4'd0)) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end
            if ((r_state == S_WAIT) && (r_waitCnt == 4'd0)) begin
                r_rspData <= dp_dataOut;
            end
        end
    end

    assign dp_dataIn = r_dpDataIn;
    assign dp_clear  = r_dpClear;
    assign rsp_data  = r_rspData;
    assign rsp_id    = r_id;

`ifdef SEQ_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [15:0] r_grantCnt;
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_grantCnt <= '0;
            end else if (w_handshake && (w_winner == ID_W'(g)) && (r_grantCnt != 16'hFFFF)) begin
                r_grantCnt <= r_grantCnt + 16'd1;
            end
        end
        assign grant_cnt[g*16 +: 16] = r_grantCnt;
    end
`endif

endmodule
`default_nettype wire
